// File: rtl/vec_ex_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : vec_ex_mem_stage
// Purpose  : Elastic EX->MEM pipeline stage for the vector CPU. A valid/ready
//            handshake with a one-entry skid buffer lets MEM stall EX without
//            dropping a beat. Per-lane masking is applied to ALU results and
//            flags at capture. Write enables are gated so bubbles never write.
//            A saturating counter records back-pressured cycles.
// Ports    : clk, reset           - falling-edge clock, async active-high reset
//            flush                - synchronous kill of held and incoming beats
//            ValidE / ReadyE      - EX-side handshake (ReadyE registered)
//            *E                   - control, address, mask and lane data from EX
//            ValidM / ReadyM      - MEM-side handshake
//            *M                   - registered beat presented to MEM
//            StallCntM            - saturating count of ValidM && !ReadyM cycles
// Revision : 1.0 - initial release
// ============================================================================
module vec_ex_mem_stage #(
  parameter int I = 32,  // scalar address width
  parameter int N = 8,   // element width per lane
  parameter int R = 6,   // lane count
  parameter int A = 4,   // destination register address width
  parameter int C = 16   // stall counter width
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           ValidE,
  output logic           ReadyE,
  input  logic           RegWriteE,
  input  logic           MemtoRegE,
  input  logic           MemWriteE,
  input  logic           FlagsWriteE,
  input  logic [1:0]     VSIFlagE,
  input  logic [A-1:0]   WA3E,
  input  logic [I-1:0]   AddressE,
  input  logic [R-1:0]   LaneMaskE,
  input  logic [R*N-1:0] ALUOutputE,
  input  logic [R*N-1:0] WriteDataE,
  input  logic [R*2-1:0] ALUFlagsE,
  output logic           ValidM,
  input  logic           ReadyM,
  output logic           RegWriteM,
  output logic           MemtoRegM,
  output logic           MemWriteM,
  output logic           FlagsWriteM,
  output logic [1:0]     VSIFlagM,
  output logic [A-1:0]   WA3M,
  output logic [I-1:0]   AddressM,
  output logic [R-1:0]   LaneMaskM,
  output logic [R*N-1:0] ALUOutputM,
  output logic [R*N-1:0] WriteDataM,
  output logic [R*2-1:0] ALUFlagsM,
  output logic [C-1:0]   StallCntM
);

  localparam logic [C-1:0] c_stall_max = {C{1'b1}};

  typedef struct packed {
    logic           regwrite;
    logic           memtoreg;
    logic           memwrite;
    logic           flagswrite;
    logic [1:0]     vsi;
    logic [A-1:0]   wa3;
    logic [I-1:0]   addr;
    logic [R-1:0]   mask;
    logic [R*N-1:0] alu;
    logic [R*N-1:0] wdata;
    logic [R*2-1:0] flags;
  } beat_t;

  beat_t          r_main;
  beat_t          r_skid;
  logic           r_main_valid;
  logic           r_skid_valid;
  logic [C-1:0]   r_stall_cnt;

  beat_t          w_in;
  logic [R*N-1:0] w_alu_masked;
  logic [R*2-1:0] w_flags_masked;
  logic           w_accept;
  logic           w_main_free;

  // Disabled lanes are zeroed here so MEM and writeback never see stale lane
  // results; write data stays raw because MEM gates byte writes with the mask.
  generate
    for (genvar i = 0; i < R; i++) begin : g_lane
      assign w_alu_masked[i*N +: N]   = LaneMaskE[i] ? ALUOutputE[i*N +: N] : '0;
      assign w_flags_masked[i*2 +: 2] = LaneMaskE[i] ? ALUFlagsE[i*2 +: 2]  : 2'b00;
    end
  endgenerate

  always_comb begin
    w_in            = '0;
    w_in.regwrite   = RegWriteE;
    w_in.memtoreg   = MemtoRegE;
    w_in.memwrite   = MemWriteE;
    w_in.flagswrite = FlagsWriteE;
    w_in.vsi        = VSIFlagE;
    w_in.wa3        = WA3E;
    w_in.addr       = AddressE;
    w_in.mask       = LaneMaskE;
    w_in.alu        = w_alu_masked;
    w_in.wdata      = WriteDataE;
    w_in.flags      = w_flags_masked;
  end

  // ReadyE comes straight from the skid valid flop, so it is registered and
  // there is no combinational path from ReadyM back to EX.
  assign ReadyE      = ~r_skid_valid;
  assign w_accept    = ValidE & ReadyE;
  // Main can take a new beat this edge if it is empty or being consumed.
  assign w_main_free = ~r_main_valid | ReadyM;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      // Data fields keep their last value; only the valids are killed.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      // Skid is older than any incoming beat, so it always wins the refill.
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_in;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end

  // Counts every cycle MEM holds off a valid beat, including a flush cycle.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !ReadyM && (r_stall_cnt != c_stall_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign ValidM      = r_main_valid;
  // Enables that cause architectural writes are masked off during bubbles.
  assign RegWriteM   = r_main.regwrite   & r_main_valid;
  assign MemWriteM   = r_main.memwrite   & r_main_valid;
  assign FlagsWriteM = r_main.flagswrite & r_main_valid;
  assign MemtoRegM   = r_main.memtoreg;
  assign VSIFlagM    = r_main.vsi;
  assign WA3M        = r_main.wa3;
  assign AddressM    = r_main.addr;
  assign LaneMaskM   = r_main.mask;
  assign ALUOutputM  = r_main.alu;
  assign WriteDataM  = r_main.wdata;
  assign ALUFlagsM   = r_main.flags;
  assign StallCntM   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vec_ex_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vec_ex_mem_stage
// Purpose  : Scoreboard bench for vec_ex_mem_stage. Stimulus pushes the
//            expected beat when EX hands it over; a monitor pops and compares
//            whenever MEM consumes a beat. Direct checks cover handshake,
//            flush, reset and stall-counter behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_ex_mem_stage;

  localparam int I = 32;
  localparam int N = 8;
  localparam int R = 6;
  localparam int A = 4;
  localparam int C = 4;

  typedef struct packed {
    logic           rw;
    logic           m2r;
    logic           mw;
    logic           fw;
    logic [1:0]     vsi;
    logic [A-1:0]   wa3;
    logic [I-1:0]   addr;
    logic [R-1:0]   mask;
    logic [R*N-1:0] alu;
    logic [R*N-1:0] wd;
    logic [R*2-1:0] flags;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset, flush, ValidE, ReadyE, ReadyM, ValidM;
  logic           RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE;
  logic           RegWriteM, MemtoRegM, MemWriteM, FlagsWriteM;
  logic [1:0]     VSIFlagE, VSIFlagM;
  logic [A-1:0]   WA3E, WA3M;
  logic [I-1:0]   AddressE, AddressM;
  logic [R-1:0]   LaneMaskE, LaneMaskM;
  logic [R*N-1:0] ALUOutputE, ALUOutputM, WriteDataE, WriteDataM;
  logic [R*2-1:0] ALUFlagsE, ALUFlagsM;
  logic [C-1:0]   StallCntM;

  beat_t exp_q[$];
  int    vectors = 0;
  int    errors  = 0;
  beat_t none    = '0;

  always #10 clk = ~clk;

  vec_ex_mem_stage #(.I(I), .N(N), .R(R), .A(A), .C(C)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ValidE(ValidE), .ReadyE(ReadyE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .FlagsWriteE(FlagsWriteE), .VSIFlagE(VSIFlagE), .WA3E(WA3E),
    .AddressE(AddressE), .LaneMaskE(LaneMaskE), .ALUOutputE(ALUOutputE),
    .WriteDataE(WriteDataE), .ALUFlagsE(ALUFlagsE),
    .ValidM(ValidM), .ReadyM(ReadyM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .FlagsWriteM(FlagsWriteM), .VSIFlagM(VSIFlagM), .WA3M(WA3M),
    .AddressM(AddressM), .LaneMaskM(LaneMaskM), .ALUOutputM(ALUOutputM),
    .WriteDataM(WriteDataM), .ALUFlagsM(ALUFlagsM), .StallCntM(StallCntM)
  );

  // Full-mask beat with a distinct pattern per destination register.
  function automatic beat_t mk(input logic [3:0] wa3, input logic mw);
    beat_t b;
    b.rw    = ~mw;
    b.m2r   = 1'b0;
    b.mw    = mw;
    b.fw    = wa3[0];
    b.vsi   = wa3[1:0];
    b.wa3   = wa3;
    b.addr  = 32'h1000_0000 | {28'd0, wa3};
    b.mask  = 6'h3F;
    b.alu   = {6{4'hA, wa3}};
    b.wd    = {6{4'h5, wa3}};
    b.flags = {6{wa3[1:0]}};
    return b;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of EX/MEM inputs; record the expected beat if EX hands it over.
  task automatic step(input logic v, input beat_t b, input beat_t e,
                      input logic rm, input logic fl);
    ValidE = v;
    {RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE, VSIFlagE, WA3E, AddressE,
     LaneMaskE, ALUOutputE, WriteDataE, ALUFlagsE} = b;
    ReadyM = rm;
    flush  = fl;
    #2;
    if (fl) exp_q.delete();
    else if (v && ReadyE) exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: a beat is consumed when ValidM && ReadyM at the coming falling edge.
  initial begin
    beat_t act, exp;
    forever begin
      @(posedge clk);
      #4;
      if (!reset && !flush && ValidM && ReadyM) begin
        act = {RegWriteM, MemtoRegM, MemWriteM, FlagsWriteM, VSIFlagM, WA3M,
               AddressM, LaneMaskM, ALUOutputM, WriteDataM, ALUFlagsM};
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got %h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL beat_wa3_%0d: got %h expected %h", exp.wa3, act, exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    beat_t b, e;
    reset = 1'b1;
    flush = 1'b0;
    ValidE = 1'b0;
    ReadyM = 1'b0;
    {RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE, VSIFlagE, WA3E, AddressE,
     LaneMaskE, ALUOutputE, WriteDataE, ALUFlagsE} = none;

    // Reset state
    @(posedge clk); #1;
    check("rst_ValidM", ValidM, 0);
    check("rst_ReadyE", ReadyE, 1);
    check("rst_StallCnt", StallCntM, 0);
    check("rst_LaneMaskM", LaneMaskM, 0);
    check("rst_ALUOutputM", ALUOutputM, 0);
    reset = 1'b0;

    // Streaming with ReadyM high
    step(1, mk(1, 0), mk(1, 0), 1, 0);
    #1 check("stream_latency", ValidM, 1);
    for (int k = 2; k <= 4; k++) step(1, mk(4'(k), 0), mk(4'(k), 0), 1, 0);
    step(0, none, none, 1, 0);
    #1 check("stream_stall", StallCntM, 0);

    // Back-pressure: 5 held in main, 6 in skid, 7 waits for ReadyE
    step(1, mk(5, 0), mk(5, 0), 1, 0);
    step(1, mk(6, 0), mk(6, 0), 0, 0);
    #1 check("bp_ReadyE_low", ReadyE, 0);
    check("bp_WA3M_hold", WA3M, 5);
    step(1, mk(7, 0), mk(7, 0), 0, 0);
    step(1, mk(7, 0), mk(7, 0), 0, 0);
    step(1, mk(7, 0), mk(7, 0), 1, 0);
    #1 check("bp_ReadyE_high", ReadyE, 1);
    check("bp_WA3M_skid", WA3M, 6);
    step(1, mk(7, 0), mk(7, 0), 1, 0);
    step(0, none, none, 1, 0);
    #1 check("bp_stall", StallCntM, 3);

    // Lane masking
    b = mk(4'hC, 1);
    b.mask  = 6'b101010;
    b.alu   = 48'hFFFF_FFFF_FFFF;
    b.wd    = 48'h1234_5678_9ABC;
    b.flags = 12'hFFF;
    e = b;
    e.alu   = 48'hFF00_FF00_FF00;
    e.flags = 12'hCCC;
    step(1, b, e, 1, 0);
    #1 check("mask_alu", ALUOutputM, 48'hFF00_FF00_FF00);
    check("mask_lanemask", LaneMaskM, 6'b101010);
    check("mask_wdata", WriteDataM, 48'h1234_5678_9ABC);
    step(0, none, none, 1, 0);

    // Flush with main and skid full and a store offered
    step(1, mk(8, 1), mk(8, 1), 0, 0);
    step(1, mk(9, 1), mk(9, 1), 0, 0);
    step(1, mk(10, 1), mk(10, 1), 0, 1);
    #1 check("flush_ValidM", ValidM, 0);
    check("flush_MemWriteM", MemWriteM, 0);
    check("flush_ReadyE", ReadyE, 1);
    check("flush_stall", StallCntM, 5);
    step(0, none, none, 1, 0);
    step(0, none, none, 1, 0);

    // Asynchronous reset between edges with skid full
    step(1, mk(11, 0), mk(11, 0), 0, 0);
    step(1, mk(12, 0), mk(12, 0), 0, 0);
    ValidE = 1'b0;
    ReadyM = 1'b0;
    #6 reset = 1'b1;
    #1 check("arst_ValidM", ValidM, 0);
    check("arst_ReadyE", ReadyE, 1);
    check("arst_StallCnt", StallCntM, 0);
    check("arst_WA3M", WA3M, 0);
    check("arst_LaneMaskM", LaneMaskM, 0);
    check("arst_ALUOutputM", ALUOutputM, 0);
    exp_q.delete();
    @(posedge clk);
    reset = 1'b0;
    step(1, mk(13, 0), mk(13, 0), 1, 0);
    #1 check("arst_first_valid", ValidM, 1);
    check("arst_first_wa3", WA3M, 13);

    // Stall counter saturation
    for (int k = 0; k < 14; k++) step(0, none, none, 0, 0);
    #1 check("sat_14", StallCntM, 14);
    for (int k = 0; k < 6; k++) step(0, none, none, 0, 0);
    #1 check("sat_15", StallCntM, 15);
    step(0, none, none, 1, 0);
    step(0, none, none, 1, 0);
    step(0, none, none, 1, 0);

    check("queue_drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_ex_mem_stage.md
# vec_ex_mem_stage

Elastic EX→MEM pipeline stage for the vector CPU, with lane count, element width and address width set by parameters. It sits between the vector ALU and the data-memory stage. It replaces a plain always-advance register with a valid/ready handshake, a one-entry skid buffer, synchronous flush, per-lane masking and a saturating stall counter. MEM can back-pressure EX without losing a beat, and bubbles never carry write enables.

## Interface
- I, 32, scalar address width (AddressE/M)
- N, 8, element width per lane
- R, 6, lane count
- A, 4, destination register address width (WA3E/M)
- C, 16, stall counter width
- clk  in  1  clock; all state updates on the falling edge
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of all held and incoming beats
- ValidE  in  1  EX presents a beat
- ReadyE  out  1  stage can accept a beat; registered
- RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE  in  1 each  control bits
- VSIFlagE  in  2  vector/scalar/immediate selector
- WA3E  in  A  destination register
- AddressE  in  I  memory address
- LaneMaskE  in  R  per-lane enable; bit i covers lane i
- ALUOutputE, WriteDataE  in  R×N  lane data
- ALUFlagsE  in  R×2  per-lane flags
- ValidM  out  1  MEM beat valid
- ReadyM  in  1  MEM consumes the beat this cycle
- RegWriteM, MemtoRegM, MemWriteM, FlagsWriteM, VSIFlagM, WA3M, AddressM, LaneMaskM, ALUOutputM, WriteDataM, ALUFlagsM  out  widths as the E side
- StallCntM  out  C  saturating count of back-pressured cycles

## Operation
- Storage: main register (drives the M outputs) plus one skid register. Each has a valid bit.
- Accept: a beat transfers when ValidE && ReadyE at the falling edge.
- ReadyE = !skid_valid, registered.
- The accepted beat goes to main if main is empty or ReadyM=1. Otherwise it goes to skid.
- Drain: when ReadyM && main_valid, main loads from skid if skid is valid, else from the incoming beat, else main_valid clears.
- Ordering is strictly FIFO, so skid always drains before any new beat reaches main.
- Masking is applied at capture: lanes with LaneMaskE[i]=0 store ALUOutput lane = 0 and ALUFlags lane = 0.
- WriteData is stored unmasked. LaneMaskM is forwarded so MEM gates byte writes per lane.
- Bubble safety: RegWriteM, MemWriteM and FlagsWriteM are ANDed with main_valid. Data outputs hold their last value while invalid.
- Flush: at the next falling edge main_valid=0, skid_valid=0 and ReadyE=1. A beat offered in the flush cycle is dropped. Flush overrides accept and drain in the same cycle.
- StallCntM increments when ValidM && !ReadyM, saturates at 2^C−1, and clears only on reset.
- Reset: all valids 0, ReadyE=1, every output 0 including StallCntM and LaneMaskM. Reset mid-transfer discards both held beats.

## Timing
- Latency is one falling edge from EX accept to ValidM when MEM is not stalling.
- Throughput is one beat per cycle with ReadyM held high.
- When ReadyM drops, at most one further beat is accepted (into skid). ReadyE falls at the edge after skid fills.
- When ReadyM rises with skid full, skid moves to main at that edge. ReadyE rises at the same edge.
- Simultaneous events:
  - Drain plus accept with skid empty: new beat goes to main.
  - Drain plus accept with skid full: cannot occur, because ReadyE=0.
- Reset is asynchronous and takes effect immediately. Its release is sampled at the next falling edge.

## Test plan
- Streaming, ReadyM=1, beats WA3=1..4 on consecutive cycles -> ValidM high from edge 1, WA3M=1,2,3,4 on consecutive edges, StallCntM=0.
- Back-pressure: ReadyM=0 for 3 cycles while EX streams WA3=5,6,7 -> WA3M holds 5, skid holds 6, ReadyE=0 after that edge. On ReadyM=1, WA3M goes 6 then 7 with no loss or duplication, and StallCntM=3.
- Lane mask: LaneMaskE=6'b101010, ALUOutputE all lanes 8'hFF -> ALUOutputM lanes 1,3,5 = FF and lanes 0,2,4 = 00. WriteDataM is unmasked and LaneMaskM=101010.
- Flush with main and skid full and MemWriteE=1 offered -> next edge ValidM=0, MemWriteM=0, ReadyE=1. The offered beat never appears.
- Reset asserted between edges while skid is full -> outputs 0 immediately. After release, the first new beat appears after one edge.
- Saturation with C=4: hold ValidM=1 and ReadyM=0 for 20 cycles -> StallCntM stops at 15.
